// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Sends one byte per request on a UART line. Each frame is one start bit
// (0), eight data bits LSB first, one parity bit and one stop bit (1). Each
// bit lasts FULL_buad+1 clocks. The parameters follow the same convention as
// uart_receiver, so both ends of a link can share one setting.
//
// Parameters
//   FULL_buad   clocks per bit minus 1 (5207 -> 9600 baud at 50 MHz)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   i_clk      system clock, rising-edge active
//   i_reset_n  asynchronous active-low reset
//   i_8_data   byte to send, sampled only on the accepting edge
//   i_send     send request, taken only while o_ready is high
//   o_ready    high while idle (decoded from the state register)
//   o_tx       registered serial output, idles high
//   o_done     one-cycle pulse when the stop bit completes
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int unsigned FULL_buad  = 5207,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_8_data,
    input  logic       i_send,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_done
);

    // A FULL_buad of 0 still needs a 1-bit counter.
    localparam int unsigned       BAUD_W   = (FULL_buad > 0) ? $clog2(FULL_buad + 1) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(FULL_buad);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic accept;
    logic bit_end;

    assign accept  = i_send && (state_q == IDLE);
    assign bit_end = (state_q != IDLE) && (baud_q == BAUD_MAX);

    // State register and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                     state_d = START;
            START:   if (bit_end)                    state_d = DATA;
            DATA:    if (bit_end && (bit_q == 3'd7)) state_d = PARITY;
            PARITY:  if (bit_end)                    state_d = STOP;
            STOP:    if (bit_end)                    state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // Output and datapath next values. o_tx is registered, so the value
    // chosen here appears on the line from the same edge the state changes.
    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        done_d   = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (accept) begin
                    shift_d  = i_8_data;
                    parity_d = (^i_8_data) ^ PARITY_ODD;
                    bit_d    = 3'd0;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d  = shift_q[0];
                    bit_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d = parity_q;
                    end else begin
                        // shift_q[1] is the bit that becomes the LSB after the shift.
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) tx_d = 1'b1;
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) done_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_tx    = tx_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Bench for uart_transmitter. It uses three instances: A (FULL_buad=9, even
// parity), B (FULL_buad=9, odd parity) and C (FULL_buad=0, even parity).
// Frames sent to A are pushed to a queue. A line monitor decodes each frame
// at mid-bit and checks it against the queue. Timing, flow-control, reset
// and parameter corner cases are checked by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] data_a, data_b, data_c;
    logic       snd_a, snd_b, snd_c;
    logic       ready_a, ready_b, ready_c;
    logic       tx_a, tx_b, tx_c;
    logic       done_a, done_b, done_c;

    uart_transmitter #(.FULL_buad(9), .PARITY_ODD(1'b0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_8_data(data_a), .i_send(snd_a),
        .o_ready(ready_a), .o_tx(tx_a), .o_done(done_a)
    );
    uart_transmitter #(.FULL_buad(9), .PARITY_ODD(1'b1)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_8_data(data_b), .i_send(snd_b),
        .o_ready(ready_b), .o_tx(tx_b), .o_done(done_b)
    );
    uart_transmitter #(.FULL_buad(0), .PARITY_ODD(1'b0)) dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_8_data(data_c), .i_send(snd_c),
        .o_ready(ready_c), .o_tx(tx_c), .o_done(done_c)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int rst_cnt = 0;

    logic [10:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t tbl[6];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;
    always @(negedge rst_n) rst_cnt++;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Line monitor for instance A: sample each bit at its middle (4.5 clocks
    // in). Frames cut short by a reset are dropped.
    always begin : mon_a
        logic [10:0] got;
        logic [10:0] exp;
        int          rst_mark;
        @(negedge tx_a);
        rst_mark = rst_cnt;
        got = '0;
        for (int i = 0; i < 11; i++) begin
            repeat ((i == 0) ? 5 : 10) @(negedge clk);
            got[i] = tx_a;
        end
        if (rst_cnt == rst_mark) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL frame_unexpected: got %0h, expected no frame", got);
            end else begin
                exp = exp_q.pop_front();
                check("frame", int'(got), int'(exp));
            end
        end
    end

    // Drive one request to A and return on the falling edge after it is accepted.
    task automatic send_a(input logic [7:0] d, input logic par);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_a && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_a_ready", int'(ready_a), 1);
        data_a = d;
        snd_a  = 1'b1;
        exp_q.push_back({1'b1, par, d, 1'b0});
        @(negedge clk);
        snd_a = 1'b0;
    endtask

    task automatic wait_idle_a(output int n);
        n = 0;
        while (!ready_a && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_a) check("wait_idle_a_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, t1, t2;
        logic [10:0] frame_c;

        tbl[0] = '{8'h55, 1'b0};
        tbl[1] = '{8'h01, 1'b1};
        tbl[2] = '{8'hFF, 1'b0};
        tbl[3] = '{8'hA3, 1'b0};
        tbl[4] = '{8'h80, 1'b1};
        tbl[5] = '{8'h3C, 1'b0};

        rst_n = 1'b0;
        snd_a = 1'b0; snd_b = 1'b0; snd_c = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        repeat (3) @(negedge clk);
        check("reset_a", int'({tx_a, ready_a, done_a}), 3'b110);
        check("reset_b", int'({tx_b, ready_b, done_b}), 3'b110);
        check("reset_c", int'({tx_c, ready_c, done_c}), 3'b110);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55: busy for 110 clocks, done pulse on the 110th edge.
        d0 = done_cnt_a;
        send_a(tbl[0].data, tbl[0].par);
        check("t1_tx_start", int'(tx_a), 0);
        wait_idle_a(n);
        check("t1_busy_len", n, 110);
        check("t1_done_high", int'(done_a), 1);
        @(negedge clk);
        check("t1_done_low", int'(done_a), 0);
        check("t1_done_count", done_cnt_a - d0, 1);

        for (int i = 1; i < 6; i++) begin
            send_a(tbl[i].data, tbl[i].par);
            wait_idle_a(n);
            check("tbl_busy_len", n, 110);
        end

        // Busy ignore: a second request at clock 40 is dropped, not queued.
        @(negedge clk);
        d0 = done_cnt_a;
        send_a(8'hA3, 1'b0);
        repeat (39) @(negedge clk);
        data_a = 8'h12;
        snd_a  = 1'b1;
        @(negedge clk);
        snd_a  = 1'b0;
        wait_idle_a(n);
        check("busy_len", n, 70);
        @(negedge clk);
        check("busy_done_count", done_cnt_a - d0, 1);
        repeat (20) @(negedge clk);
        check("busy_not_queued", int'({ready_a, tx_a}), 2'b11);

        // Back-to-back: i_send held high.
        d0 = done_cnt_a;
        data_a = 8'h0F;
        snd_a  = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 8'h0F, 1'b0});
        exp_q.push_back({1'b1, 1'b0, 8'hF0, 1'b0});
        @(negedge clk);
        data_a = 8'hF0;
        n = 0;
        while (!done_a && n < 1000) begin @(negedge clk); n++; end
        check("b2b_first_len", n, 110);
        t1 = cyc;
        check("b2b_idle_gap", int'({ready_a, tx_a}), 2'b11);
        @(negedge clk);
        check("b2b_second_accept", int'({ready_a, tx_a}), 2'b00);
        snd_a = 1'b0;
        n = 0;
        while (!done_a && n < 1000) begin @(negedge clk); n++; end
        t2 = cyc;
        check("b2b_done_spacing", t2 - t1, 111);
        @(negedge clk);
        check("b2b_done_count", done_cnt_a - d0, 2);

        // Reset in the middle of a 0x00 frame.
        d0 = done_cnt_a;
        @(negedge clk);
        data_a = 8'h00;
        snd_a  = 1'b1;
        @(negedge clk);
        snd_a  = 1'b0;
        repeat (34) @(negedge clk);
        check("rst_mid_tx_low_before", int'(tx_a), 0);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_async", int'({tx_a, ready_a, done_a}), 3'b110);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("rst_mid_no_done", done_cnt_a - d0, 0);
        check("rst_mid_idle", int'({ready_a, tx_a}), 2'b11);
        send_a(8'h3C, 1'b0);
        wait_idle_a(n);
        check("rst_after_len", n, 110);

        // Odd parity instance: 0xFF gives parity 1, 0x01 gives parity 0.
        @(negedge clk);
        data_b = 8'hFF; snd_b = 1'b1;
        @(negedge clk);
        snd_b = 1'b0;
        repeat (94) @(negedge clk);
        check("odd_par_ff", int'(tx_b), 1);
        n = 0;
        while (!ready_b && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        data_b = 8'h01; snd_b = 1'b1;
        @(negedge clk);
        snd_b = 1'b0;
        repeat (14) @(negedge clk);
        check("odd_d0_01", int'(tx_b), 1);
        repeat (80) @(negedge clk);
        check("odd_par_01", int'(tx_b), 0);
        n = 0;
        while (!ready_b && n < 1000) begin @(negedge clk); n++; end
        check("odd_idle", int'(ready_b), 1);

        // One clock per bit: 0x81 -> 0,1,0,0,0,0,0,0,1,0,1 (bit 0 first).
        frame_c = 11'b101_0000_0010;
        @(negedge clk);
        data_c = 8'h81; snd_c = 1'b1;
        @(negedge clk);
        snd_c = 1'b0;
        for (int k = 0; k < 11; k++) begin
            check("fb0_bit", int'({done_c, ready_c, tx_c}), int'({2'b00, frame_c[k]}));
            @(negedge clk);
        end
        check("fb0_done", int'({done_c, ready_c, tx_c}), 3'b111);
        @(negedge clk);
        check("fb0_done_low", int'(done_c), 0);

        repeat (200) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises one byte per request onto a UART line. The frame is 1 start bit, 8 data bits LSB first, 1 parity bit and 1 stop bit, which is the same frame uart_receiver accepts. The block sits between the design's data sources and the board TX pin, and loops back to uart_receiver in system tests. It uses the same baud-count parameter convention as uart_receiver, so both ends share one setting.

Parameters:
FULL_buad, 5207, clocks per bit minus 1. Each bit lasts FULL_buad+1 clocks; the default gives 9600 baud at 50 MHz.
PARITY_ODD, 0, 0 selects even parity (uart_receiver's setting); 1 selects odd parity.

Ports:
i_clk  input  1  system clock; all state changes on the rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_8_data  input  8  byte to send; sampled only on the accepting edge
i_send  input  1  send request; qualified by o_ready
o_ready  output  1  high when idle and able to accept a byte
o_tx  output  1  serial line, registered; idles high
o_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_tx=1, o_ready=1, o_done=0.
  - State IDLE, bit counter 0, baud counter 0, shift register 0.
- States: IDLE, START, DATA, PARITY, STOP.
- o_ready = (state==IDLE), decoded from the state register only, with no combinational path from i_send.
- Accept rule: a byte is accepted on a rising edge where i_send=1 and o_ready=1. On that edge:
  - Latch i_8_data into the shift register.
  - Compute parity = XOR(i_8_data) XOR PARITY_ODD.
  - Set o_tx=0 and go to START with the baud counter cleared.
  - The start bit therefore begins on the accepting edge.
- Baud counter: counts 0..FULL_buad and wraps to 0 at the end of every bit. A bit ends on the edge where the counter equals FULL_buad.
- START ends -> DATA, o_tx = data[0].
- DATA: on each bit end, shift right and drive the next bit. After bit 7 ends -> PARITY, o_tx = parity bit.
- PARITY ends -> STOP, o_tx=1.
- STOP ends -> IDLE, o_tx stays 1, o_done=1 for exactly that one cycle.
- Timing:
  - Frame length is 11*(FULL_buad+1) clocks from the accepting edge to the IDLE edge.
  - o_done rises on the IDLE edge.
  - The earliest next accept is the edge after that, so there is at least 1 idle clock between frames.
- Flow control:
  - i_send while o_ready=0 is ignored, and the request is not queued.
  - Changes on i_8_data during a frame have no effect.
  - i_send held high continuously produces back-to-back frames, each separated by exactly 1 idle clock.
- Reset mid-frame:
  - o_tx goes to 1 immediately on assertion and the frame is abandoned.
  - o_done is not pulsed.
  - After release the block is in IDLE with o_ready=1.
- FULL_buad=0 is legal: 1 clock per bit, 11-clock frame.
- Widths:
  - Baud counter is wide enough to hold FULL_buad.
  - Bit counter is 3 bits; DATA exits after count 7.
  - No wrap other than the baud counter and the end-of-frame return to IDLE.

Test Plan:
1. FULL_buad=9, send 0x55 -> o_tx per 10 clocks: 0, 1,0,1,0,1,0,1,0, 0 (parity), 1 (stop). o_ready low for 110 clocks; o_done pulses once at the 110th edge after accept. Loop-back into uart_receiver (FULL_buad=9, HALF_buad=3) gives o_8_data=0x55 and o_ready=1.
2. Parity: send 0x01 -> parity bit 1. Send 0xFF -> parity bit 0. With PARITY_ODD=1, send 0xFF -> parity bit 1.
3. Busy ignore: send 0xA3, pulse i_send with i_8_data=0x12 at clock 40 -> only the 0xA3 frame appears; exactly one o_done pulse.
4. Back-to-back: i_send held high with 0x0F then 0xF0 -> two frames, exactly 1 idle clock (o_tx=1, o_ready=1) between them; two o_done pulses 111 clocks apart.
5. Reset mid-frame: assert i_reset_n=0 at clock 35 of a 0x00 frame -> o_tx=1 asynchronously, no o_done. After release, send 0x3C -> a correct frame.
6. FULL_buad=0: send 0x81 -> 11-clock frame 0,1,0,0,0,0,0,0,1,0,1; o_done at clock 11.
